// File: rtl/alu_sequencer.sv
// Multi-cycle controller in front of a combinational ALU: single ops in one execute cycle,
// MUL as a shift-and-add loop on the ALU adder. Optional macro: ALU_SEQ_FAST_ZERO_EN.
module alu_sequencer #(
    parameter int unsigned BITS   = 8,
    parameter int unsigned CTRL_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [3:0]          req_op_i,
    input  logic [BITS-1:0]     req_a_i,
    input  logic [BITS-1:0]     req_b_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [2*BITS-1:0]   resp_data_o,
    output logic                resp_err_o,
    output logic [BITS-1:0]     alu_a_o,
    output logic [BITS-1:0]     alu_b_o,
    output logic [CTRL_W-1:0]   alu_ctrl_o,
    input  logic [BITS-1:0]     alu_s_i
);

    localparam int unsigned CntW  = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [3:0]  OpMul = 4'd8;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StMul,
        StZero,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    // opa holds A for single ops and the multiplicand M for MUL;
    // opb holds B for single ops and the shifting multiplier Q for MUL.
    logic [BITS-1:0]     opa_q, opa_d;
    logic [BITS-1:0]     opb_q, opb_d;
    logic [BITS-1:0]     acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2*BITS-1:0]   data_q, data_d;
    logic                err_q, err_d;

    logic [BITS-1:0]     sum;
    logic                carry;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        err_d        = err_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        alu_a_o      = '0;
        alu_b_o      = '0;
        alu_ctrl_o   = '0;
        sum          = acc_q;
        carry        = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    op_d  = req_op_i[2:0];
                    opa_d = req_a_i;
                    opb_d = req_b_i;
                    acc_d = '0;
                    cnt_d = '0;
                    if (req_op_i < OpMul) begin
                        state_d = StExec;
                    end else if (req_op_i == OpMul) begin
`ifdef ALU_SEQ_FAST_ZERO_EN
                        state_d = (req_a_i == '0 || req_b_i == '0) ? StZero : StMul;
`else
                        state_d = StMul;
`endif
                    end else begin
                        state_d = StDone;
                        data_d  = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            StExec: begin
                alu_a_o    = opa_q;
                alu_b_o    = opb_q;
                alu_ctrl_o = CTRL_W'(op_q);
                data_d     = {{BITS{1'b0}}, alu_s_i};
                err_d      = 1'b0;
                state_d    = StDone;
            end
            StMul: begin
                alu_a_o = acc_q;
                alu_b_o = opa_q;
                if (opb_q[0]) begin
                    sum   = alu_s_i;
                    carry = (alu_s_i < acc_q);
                end
                // {C,A,Q} shifted right by one; the carry lands in A's MSB.
                acc_d = {carry, sum[BITS-1:1]};
                opb_d = {sum[0], opb_q[BITS-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(BITS - 1)) begin
                    state_d = StDone;
                    data_d  = {acc_d, opb_d};
                    err_d   = 1'b0;
                end
            end
            StZero: begin
                data_d  = '0;
                err_d   = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign resp_data_o = data_q;
    assign resp_err_o  = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random ops against a
// behavioural model (ALU ops by table, MUL by plain multiplication).
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        resp_err;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_ctrl;
    logic [7:0]  alu_s;

    int checks = 0;
    int errors = 0;

`ifdef ALU_SEQ_FAST_ZERO_EN
    localparam bit FastZero = 1'b1;
`else
    localparam bit FastZero = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_sequencer #(.BITS(8), .CTRL_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_err_o   (resp_err),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_ctrl_o   (alu_ctrl),
        .alu_s_i      (alu_s)
    );

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a << 1;
            3'd3:    return a >> 1;
            3'd4:    return a | b;
            3'd5:    return a & b;
            3'd6:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Combinational ALU sitting on the other side of the sequencer.
    assign alu_s = alu_fn(alu_ctrl[2:0], alu_a, alu_b);

    function automatic logic [15:0] ref_data(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        if (op > 4'd8) return 16'h0000;
        if (op == 4'd8) return 16'({8'h00, a} * {8'h00, b});
        return {8'h00, alu_fn(op[2:0], a, b)};
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [7:0] a,
                                   input logic [7:0] b);
        if (op > 4'd8) return 0;
        if (op == 4'd8) return (FastZero && (a == 8'h00 || b == 8'h00)) ? 1 : 8;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold = cycles of response backpressure after valid appears.
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold);
        int lat;
        logic [15:0] exp_d;
        exp_d = ref_data(op, a, b);
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_alu_ctrl", 32'(alu_ctrl), 32'd0);
        req_valid  = 1'b1;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        resp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        if (op < 4'd8) begin
            check("exec_alu_a", 32'(alu_a), 32'(a));
            check("exec_alu_b", 32'(alu_b), 32'(b));
            check("exec_alu_ctrl", 32'(alu_ctrl), 32'(op[2:0]));
        end else if (ref_lat(op, a, b) == 8) begin
            check("mul_alu_ctrl", 32'(alu_ctrl), 32'd0);
            check("mul_alu_b", 32'(alu_b), 32'(a));
        end
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(ref_lat(op, a, b)));
        check("resp_data", 32'(resp_data), 32'(exp_d));
        check("resp_err", 32'(resp_err), 32'(op > 4'd8));
        check("busy_ready", 32'(req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("held_valid", 32'(resp_valid), 32'd1);
            check("held_data", 32'(resp_data), 32'(exp_d));
            check("held_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("consumed_valid", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 4'h0;
        req_a      = 8'h00;
        req_b      = 8'h00;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst_data", 32'(resp_data), 32'd0);
        rst = 1'b0;

        do_op(4'd0, 8'h05, 8'h03, 0);
        check("add_model", 32'(ref_data(4'd0, 8'h05, 8'h03)), 32'h0008);
        do_op(4'd1, 8'h03, 8'h05, 0);
        do_op(4'd8, 8'hFF, 8'hFF, 0);
        do_op(4'd8, 8'h00, 8'h37, 0);
        do_op(4'hC, 8'h5A, 8'hA5, 2);
        do_op(4'd7, 8'h3C, 8'hFF, 1);

        // Backpressure with a competing request that must be ignored.
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = 4'd4;
        req_a      = 8'hA0;
        req_b      = 8'h0A;
        resp_ready = 1'b0;
        @(negedge clk);
        req_op = 4'd0;
        req_a  = 8'h11;
        req_b  = 8'h22;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_data", 32'(resp_data), 32'h00AA);
            check("bp_ready", 32'(req_ready), 32'd0);
            if (i < 4) @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("bp_no_accept_valid", 32'(resp_valid), 32'd0);
        check("bp_no_accept_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of a multiply.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd8;
        req_a     = 8'h12;
        req_b     = 8'h34;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", 32'(resp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("midrst_data", 32'(resp_data), 32'd0);
        do_op(4'd8, 8'h02, 8'h03, 0);

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = 4'd8;
            a = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            do_op(op, a, b, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that sits between a requester (register file / decode stage) and the combinational ALU.
- Accepts one operation at a time over a valid/ready handshake.
- Single ALU ops are passed through in one execute cycle.
- MUL is sequenced as a BITS-iteration shift-and-add loop using the ALU adder.
- The 2*BITS-bit result is returned over a valid/ready response channel.

Parameters:
BITS, 8, operand width; must match the ALU instance's BITS.
CTRL_W, 4, width of the ALU control bus (= BITS+1 of the ALU when BITS=3; fixed 4 for this block, only low 3 bits encode the op).

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready; high only in IDLE
req_op_i  in  4  0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 OR, 5 AND, 6 XOR, 7 NOT, 8 MUL, 9-15 illegal
req_a_i  in  BITS  operand A
req_b_i  in  BITS  operand B
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response accepted
resp_data_o  out  2*BITS  result
resp_err_o  out  1  illegal opcode
alu_a_o  out  BITS  to ALU bus_a_i
alu_b_o  out  BITS  to ALU bus_b_i
alu_ctrl_o  out  CTRL_W  to ALU control_i
alu_s_i  in  BITS  from ALU bus_s_o

Behaviour:
- Reset (sync, priority over everything, usable mid-operation):
  - state=IDLE, all outputs 0 except req_ready_o=1.
  - Internal A/Q/M/C/count cleared.
  - An in-flight op or pending response is discarded.
- States:
  - IDLE: req_ready_o=1. On req_valid_i at edge n, latch op/a/b.
    - op 0-7 -> EXEC.
    - op 8 -> MUL, with A=0, C=0, Q=req_b_i, M=req_a_i, count=0.
    - op 9-15 -> DONE with resp_err_o=1, resp_data_o=0, so resp_valid_o is high after edge n.
  - EXEC: alu_a_o=a, alu_b_o=b, alu_ctrl_o=op[2:0] zero-extended. At edge n+1, resp_data_o={BITS'b0, alu_s_i}, resp_err_o=0, go to DONE. Latency: resp_valid_o high after edge n+1.
  - MUL: alu_a_o=A, alu_b_o=M, alu_ctrl_o=0 (ADD). Each edge:
    - if Q[0]: sum=alu_s_i, C=(sum<A) unsigned; else sum=A, C=0.
    - {C,A,Q} <= {C,sum,Q} >> 1 (logical), count++.
    - When count reaches BITS-1 (the BITS-th iteration edge, n+BITS), go to DONE with resp_data_o={A,Q} after that shift. Result is the unsigned product mod 2^(2*BITS), exact.
  - DONE: resp_valid_o=1. resp_data_o and resp_err_o are held stable while resp_ready_i=0. On resp_valid_o&&resp_ready_i go to IDLE and drop resp_valid_o; no new request is accepted in that same cycle.
- ALU drive outside EXEC/MUL: alu_a_o=0, alu_b_o=0, alu_ctrl_o=0.
- Request inputs are ignored when req_ready_o=0.
- Overflow/carry of single ALU ops is not reported.
- NOT ignores req_b_i.

Optional Feature:
ALU_SEQ_FAST_ZERO_EN
- Defined: a MUL accepted with req_a_i==0 or req_b_i==0 skips the loop. It goes directly to DONE at edge n+1 with resp_data_o=0, resp_err_o=0.
- Undefined: every MUL takes the full BITS iterations regardless of operands.

Test Plan:
- Reset: hold rst_i 2 cycles -> resp_valid_o=0, req_ready_o=1, alu_ctrl_o=0, resp_data_o=0.
- ADD: op=0, a=8'h05, b=8'h03, resp_ready_i=1 -> resp_valid_o after edge n+1, resp_data_o=16'h0008. SUB: a=8'h03, b=8'h05 -> 16'h00FE.
- MUL: a=8'hFF, b=8'hFF -> resp_valid_o exactly after edge n+8, resp_data_o=16'hFE01, resp_err_o=0. With ALU_SEQ_FAST_ZERO_EN, a=8'h00, b=8'h37 -> 16'h0000 after edge n+1; without the macro, after edge n+8.
- Illegal op=4'hC -> resp_valid_o after edge n, resp_err_o=1, resp_data_o=0; req_ready_o=0 until consumed.
- Backpressure: OR a=8'hA0, b=8'h0A with resp_ready_i=0 for 5 cycles -> resp_data_o held at 16'h00AA and req_ready_o=0 throughout; a second req_valid_i in that window is not accepted.
- Reset mid-MUL: assert rst_i at iteration 4 of 8'h12*8'h34 -> after that edge state IDLE, resp_valid_o=0. A following MUL 8'h02*8'h03 returns 16'h0006.
